// File: rtl/prediction_stat_tracker_pkg.sv
// Shared types and constants for the prediction statistics tracker.
// Trend encodings are one-hot of the 2-bit hit history {latest, prev}.
package prediction_stat_tracker_pkg;

    localparam logic [3:0] TREND_BOTH_MISS   = 4'b0001;
    localparam logic [3:0] TREND_PREV_HIT    = 4'b0010;
    localparam logic [3:0] TREND_LATEST_HIT  = 4'b0100;
    localparam logic [3:0] TREND_BOTH_HIT    = 4'b1000;

    localparam int         STAT_MISS_PENALTY = 2;
    localparam logic [1:0] HISTORY_RESET     = 2'b11;

    typedef struct packed {
        logic sp;
        logic lhp;
        logic ghp;
    } pred_entry_t;

    function automatic logic [3:0] trend_decode_of(input logic [1:0] history);
        logic [3:0] trend;
        unique case (history)
            2'b00:   trend = TREND_BOTH_MISS;
            2'b01:   trend = TREND_PREV_HIT;
            2'b10:   trend = TREND_LATEST_HIT;
            default: trend = TREND_BOTH_HIT;
        endcase
        return trend;
    endfunction

endpackage

// File: rtl/prediction_stat_tracker_stat_unit.sv
// Per-predictor scoring unit: saturating confidence counter, 2-bit hit
// history with one-hot trend decode, and an optional halving (decay) hook.
module prediction_stat_tracker_stat_unit
    import prediction_stat_tracker_pkg::*;
#(
    parameter int STAT_COUNTER_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          score_valid,
    input  logic                          hit,
    input  logic                          decay,
    output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
    output logic [3:0]                    trend_decode
);

    localparam logic [STAT_COUNTER_WIDTH-1:0] COUNT_MAX    = '1;
    localparam logic [STAT_COUNTER_WIDTH-1:0] COUNT_ONE    = STAT_COUNTER_WIDTH'(1);
    localparam logic [STAT_COUNTER_WIDTH-1:0] MISS_PENALTY = STAT_COUNTER_WIDTH'(STAT_MISS_PENALTY);

    logic [STAT_COUNTER_WIDTH-1:0] count_q;
    logic [STAT_COUNTER_WIDTH-1:0] scored_count;
    logic [STAT_COUNTER_WIDTH-1:0] next_count;
    logic [1:0]                    history_q;

    // Decay is applied on top of the hit/miss result of the same resolve.
    always_comb begin
        scored_count = count_q;
        if (hit) begin
            scored_count = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + COUNT_ONE;
        end else begin
            scored_count = (count_q < MISS_PENALTY) ? '0 : count_q - MISS_PENALTY;
        end
        next_count = decay ? (scored_count >> 1) : scored_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            history_q <= HISTORY_RESET;
        end else if (score_valid) begin
            count_q   <= next_count;
            history_q <= {hit, history_q[1]};
        end
    end

    assign stat_count   = count_q;
    assign trend_decode = trend_decode_of(history_q);

endmodule

// File: rtl/prediction_stat_tracker.sv
// Queues raw SP/LHP/GHP predictions and scores them at resolve time.
// Optional counter decay is enabled by defining STAT_DECAY_EN.
module prediction_stat_tracker
    import prediction_stat_tracker_pkg::*;
#(
    parameter int STAT_COUNTER_WIDTH = 5,
    parameter int FIFO_DEPTH         = 8,
    parameter int DECAY_PERIOD       = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pred_valid,
    input  logic                          SP_pred,
    input  logic                          LHP_pred,
    input  logic                          GHP_pred,
    output logic                          pred_ready,
    input  logic                          resolve_valid,
    input  logic                          resolve_taken,
    input  logic                          flush,
    output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
    output logic [3:0]                    SP_trend_decode,
    output logic [3:0]                    LHP_trend_decode,
    output logic [3:0]                    GHP_trend_decode,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          orphan_resolve
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DECAY_PERIOD < 1) begin : g_param_check
        $error("prediction_stat_tracker: FIFO_DEPTH must be a power of 2 >= 2 and DECAY_PERIOD >= 1");
    end

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    pred_entry_t    fifo_mem [FIFO_DEPTH];
    pred_entry_t    head;
    logic           push;
    logic           pop;
    logic           decay_event;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pred_ready = !fifo_full || (resolve_valid && !fifo_empty);
    assign push       = pred_valid && pred_ready && !flush;
    assign pop        = resolve_valid && !fifo_empty;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {SP_pred, LHP_pred, GHP_pred};
        end
    end

    // Flush wins over pointer movement; the head entry is still scored this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            orphan_resolve <= 1'b0;
        end else begin
            orphan_resolve <= resolve_valid && fifo_empty;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

`ifdef STAT_DECAY_EN
    localparam int DECAY_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);

    logic [DECAY_W-1:0] decay_cnt;

    assign decay_event = pop && (decay_cnt == DECAY_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decay_cnt <= '0;
        end else if (pop) begin
            decay_cnt <= (decay_cnt == DECAY_LAST) ? '0 : decay_cnt + DECAY_W'(1);
        end
    end
`else
    assign decay_event = 1'b0;
`endif

    prediction_stat_tracker_stat_unit #(
        .STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH)
    ) sp_unit (
        .clk         (clk),
        .rst         (rst),
        .score_valid (pop),
        .hit         (head.sp == resolve_taken),
        .decay       (decay_event),
        .stat_count  (SP_stat_count),
        .trend_decode(SP_trend_decode)
    );

    prediction_stat_tracker_stat_unit #(
        .STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH)
    ) lhp_unit (
        .clk         (clk),
        .rst         (rst),
        .score_valid (pop),
        .hit         (head.lhp == resolve_taken),
        .decay       (decay_event),
        .stat_count  (LHP_stat_count),
        .trend_decode(LHP_trend_decode)
    );

    prediction_stat_tracker_stat_unit #(
        .STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH)
    ) ghp_unit (
        .clk         (clk),
        .rst         (rst),
        .score_valid (pop),
        .hit         (head.ghp == resolve_taken),
        .decay       (decay_event),
        .stat_count  (GHP_stat_count),
        .trend_decode(GHP_trend_decode)
    );

endmodule
